mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL be even and >= 4.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  operation select: 00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- hi  out  WIDTH  mult: upper product half; div: remainder.
- lo  out  WIDTH  mult: lower product half; div: quotient.
- busy  out  1  high from the accepting edge until the edge that raises done.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  divide-by-zero flag; valid while done=1, 0 otherwise.

Function
REQ-004 FSM states SHALL be IDLE, CALC, FIX, DONE and DZ.
REQ-005 IDLE with start=1 at edge E0:
- a, b and op latched; counter cleared.
- Goes to DZ if op[1]=1 and b=0; otherwise goes to CALC.
REQ-006 a, b and op changes after E0 SHALL NOT affect the operation in progress.
REQ-007 CALC SHALL take exactly WIDTH edges, one iteration per edge, then go to FIX.
- Mult: shift-add on operand magnitudes.
- Div: restoring division on operand magnitudes.
REQ-008 FIX SHALL take one edge, apply sign correction, write hi/lo, then go to DONE.
REQ-009 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
- For a normal operation, done is high in the cycle after edge E0+WIDTH+1.
REQ-010 Signed mult SHALL produce the 2*WIDTH-bit two's-complement product as {hi,lo}.
REQ-011 Unsigned mult SHALL produce the 2*WIDTH-bit unsigned product as {hi,lo}.
REQ-012 Signed div: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-013 Signed div of the most-negative value by -1:
- lo SHALL be the most-negative value (wrap), hi SHALL be 0.
- No flag SHALL be raised.
REQ-014 Unsigned div SHALL treat both operands as unsigned.
REQ-015 DZ SHALL take one edge, then go to IDLE.
- done=1 and div_zero=1 in the cycle after E0+1.
- hi and lo keep their previous values.
REQ-016 busy SHALL equal 1 in CALC, FIX and DZ, and 0 in IDLE and DONE.
REQ-017 start in any state other than IDLE SHALL be ignored and not queued.
- start high in the DONE cycle SHALL be ignored.
- A new operation requires start high in IDLE.
REQ-018 hi and lo SHALL change only at the FIX edge.
- They hold until the next completed non-zero-divisor operation.
REQ-019 Back-to-back operations: start held high continuously SHALL begin a new operation at the first IDLE edge after DONE.

Reset
REQ-020 reset low SHALL immediately force:
- state IDLE, counter 0;
- hi=0, lo=0, busy=0, done=0, div_zero=0;
- internal operand registers 0.
REQ-021 reset asserted mid-operation SHALL abandon the operation without a done pulse.
REQ-022 reset deassertion SHALL be synchronised so the first accepted start occurs at least one full cycle after release.

Verification (WIDTH=32)
REQ-023 Signed mult:
- Stimulus: op=00, a=0xFFFFFFFD, b=7.
- Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle only, 34 cycles after the start edge; busy high for exactly 33 cycles.
REQ-024 Unsigned mult:
- Stimulus: op=01, a=b=0xFFFFFFFF.
- Required: hi=0xFFFFFFFE, lo=0x00000001.
- Repeat with op=00: hi=0x00000000, lo=0x00000001.
REQ-025 Signed div:
- Stimulus: op=10, a=0xFFFFFFF9 (-7), b=2.
- Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Then a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
REQ-026 Divide by zero:
- Prior state: hi=0x12345678, lo=0x9ABCDEF0.
- Stimulus: op=11, b=0.
- Required: done=div_zero=1 two cycles after start; hi/lo unchanged.
REQ-027 Start while busy, then reset mid-operation:
- Second start pulse during CALC: ignored, only one done.
- reset low 10 cycles into CALC: all outputs 0 immediately, no done.
- After release: fresh op=01, a=3, b=5 gives lo=15, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, WIDTH iterations, followed by one sign-correction cycle.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, DZ} stateT;

   stateT              state, stateNext;
   logic [1:0]         armSync;
   logic [CNT_W-1:0]   cnt;
   logic               isDiv, negLo, negHi;
   logic [WIDTH-1:0]   accReg, qReg, opB;

   logic               accept, lastIter, isSigned;
   logic [WIDTH-1:0]   aMag, bMag;
   logic [WIDTH:0]     mulSum, divShift, divTrial;
   logic [2*WIDTH-1:0] product, productFix;
   logic [WIDTH-1:0]   quotFix, remFix;

   assign isSigned = ~op[0];
   assign aMag     = (isSigned && a[WIDTH-1]) ? -a : a;
   assign bMag     = (isSigned && b[WIDTH-1]) ? -b : b;
   assign accept   = (state == IDLE) && start && armSync[1];
   assign lastIter = (cnt == CNT_W'(WIDTH - 1));

   // One iteration of each algorithm; {accReg, qReg} is the shared working pair.
   assign mulSum     = {1'b0, accReg} + (qReg[0] ? {1'b0, opB} : '0);
   assign divShift   = {accReg, qReg[WIDTH-1]};
   assign divTrial   = divShift - {1'b0, opB};
   assign product    = {accReg, qReg};
   assign productFix = negLo ? -product : product;
   assign quotFix    = negLo ? -qReg : qReg;
   assign remFix     = negHi ? -accReg : accReg;

   // Release of reset is walked through two flops before start can be accepted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         armSync <= 2'b00;
      end else begin
         armSync <= {armSync[0], 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = (op[1] && (b == '0)) ? DZ : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (lastIter) begin
               stateNext = FIX;
            end
         end
         FIX: begin
            busy      = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            stateNext = IDLE;
         end
         DZ: begin
            busy      = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         isDiv    <= 1'b0;
         negLo    <= 1'b0;
         negHi    <= 1'b0;
         accReg   <= '0;
         qReg     <= '0;
         opB      <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         // done/div_zero rise on the edge that leaves FIX or DZ.
         done     <= (state == FIX) || (state == DZ);
         div_zero <= (state == DZ);
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  isDiv  <= op[1];
                  negLo  <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                  negHi  <= isSigned && a[WIDTH-1];
                  accReg <= '0;
                  qReg   <= aMag;
                  opB    <= bMag;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (isDiv) begin
                  accReg <= divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
                  qReg   <= {qReg[WIDTH-2:0], ~divTrial[WIDTH]};
               end else begin
                  accReg <= mulSum[WIDTH:1];
                  qReg   <= {mulSum[0], qReg[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (isDiv) begin
                  hi <= remFix;
                  lo <= quotFix;
               end else begin
                  hi <= productFix[2*WIDTH-1:WIDTH];
                  lo <= productFix[WIDTH-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle, plus
// directed operations with hand-computed results, latency and pulse checks.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [W-1:0]  hi, lo;
   logic          busy, done, div_zero;

   int nChecks = 0;
   int nFail = 0;

   mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {hi, lo} for a completed non-zero-divisor operation.
   function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint      sx, sy, sq, sr;
      logic [63:0] ux, uy, uq, ur;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      res = '0;
      case (o)
         2'b00: res = 64'(sx * sy);
         2'b01: res = ux * uy;
         2'b10: begin
            if (y != 0) begin
               sq  = sx / sy;
               sr  = sx % sy;
               res = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (y != 0) begin
               uq  = ux / uy;
               ur  = ux % uy;
               res = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Timeline model: an accepted request keeps the unit busy for W+1 cycles (1 for a
   // zero divisor), then done pulses for one cycle; results appear with done.
   int          mBusyLeft = 0;
   int          armCnt = 0;
   logic        mDone = 1'b0, mDz = 1'b0, pDz = 1'b0;
   logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;
   logic        mAccept;
   logic        reqDz;

   assign reqDz   = op[1] && (b == '0);
   assign mAccept = start && (armCnt >= 2) && (mBusyLeft == 0) && !(mDone && !mDz);

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mBusyLeft <= 0;
         armCnt    <= 0;
         mDone     <= 1'b0;
         mDz       <= 1'b0;
         pDz       <= 1'b0;
         mHi       <= '0;
         mLo       <= '0;
      end else begin
         armCnt <= (armCnt < 2) ? armCnt + 1 : armCnt;
         mDone  <= (mBusyLeft == 1);
         mDz    <= (mBusyLeft == 1) && pDz;
         if (mBusyLeft == 1 && !pDz) begin
            mHi <= pHi;
            mLo <= pLo;
         end
         if (mAccept) begin
            mBusyLeft  <= reqDz ? 1 : W + 1;
            pDz        <= reqDz;
            {pHi, pLo} <= refResult(op, a, b);
         end else if (mBusyLeft > 0) begin
            mBusyLeft <= mBusyLeft - 1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         check("cyc_busy", 64'(busy), 64'(mBusyLeft > 0));
         check("cyc_done", 64'(done), 64'(mDone));
         check("cyc_dz", 64'(div_zero), 64'(mDz));
         check("cyc_hi", 64'(hi), 64'(mHi));
         check("cyc_lo", 64'(lo), 64'(mLo));
      end
   end

   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eHi, input logic [31:0] eLo,
                        input logic eDz);
      int lat, busyCyc;
      bit seen;
      @(negedge clock);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0; a = ~x; b = y + 1; op = ~o;
      lat = 0; busyCyc = 0; seen = 0;
      while (!seen && lat < 200) begin
         @(negedge clock);
         lat++;
         if (busy) busyCyc++;
         if (done) seen = 1;
      end
      check({tag, "_latency"}, 64'(lat), eDz ? 64'd2 : 64'(W + 2));
      check({tag, "_busycyc"}, 64'(busyCyc), eDz ? 64'd1 : 64'(W + 1));
      check({tag, "_hi"}, 64'(hi), 64'(eHi));
      check({tag, "_lo"}, 64'(lo), 64'(eLo));
      check({tag, "_dz"}, 64'(div_zero), 64'(eDz));
      $display("%s op=%b a=%h b=%h -> hi=%h lo=%h dz=%b latency=%0d busy=%0d",
               tag, o, x, y, hi, lo, div_zero, lat, busyCyc);
      @(negedge clock);
      check({tag, "_donewidth"}, 64'(done), 64'd0);
   endtask

   initial begin
      int nDone, first, second, idx;
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      // Start already high when reset is released: the first edge must not accept it.
      start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
      #3 reset = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check("release_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clock);

      runOp("smul",     2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      runOp("umul",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      runOp("smul_m1",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      runOp("smul_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      runOp("sdiv",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      runOp("sdiv_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      runOp("sdiv_pn",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      runOp("sdiv_nn",  2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0);
      runOp("udiv",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      runOp("udiv_big", 2'b11, 32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0);
      runOp("umul_set", 2'b01, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0);
      runOp("udiv_z",   2'b11, 32'd55,       32'd0,        32'h1,        32'h23456780, 1'b1);
      runOp("sdiv_z",   2'b10, 32'h80000000, 32'd0,        32'h1,        32'h23456780, 1'b1);

      // A second start pulse while busy is dropped.
      @(negedge clock);
      op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      nDone = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (i == 5) begin
            start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
         end
         if (i == 6) start = 1'b0;
         if (done) nDone++;
      end
      check("busystart_dones", 64'(nDone), 64'd1);
      check("busystart_lo", 64'(lo), 64'd63);
      check("busystart_hi", 64'(hi), 64'd0);
      $display("busystart op=01 a=7 b=9 -> hi=%h lo=%h dones=%0d", hi, lo, nDone);

      // Reset ten cycles into the calculation.
      @(negedge clock);
      op = 2'b01; a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (10) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_dz", 64'(div_zero), 64'd0);
      repeat (2) @(negedge clock);
      #3 reset = 1'b1;
      nDone = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (done) nDone++;
      end
      check("midrst_nodone", 64'(nDone), 64'd0);
      $display("midreset abandoned op=01 a=100 b=100 dones=%0d", nDone);
      runOp("post_rst", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

      // Start held high: the next operation begins on the first IDLE edge after DONE.
      @(negedge clock);
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
      first = -1; second = -1; idx = 0;
      while (second < 0 && idx < 200) begin
         @(negedge clock);
         idx++;
         if (done) begin
            if (first < 0) first = idx;
            else begin
               second = idx;
               start = 1'b0;
            end
         end
      end
      check("b2b_gap", 64'(second - first), 64'(W + 3));
      check("b2b_lo", 64'(lo), 64'd6);
      $display("b2b op=01 a=2 b=3 -> lo=%h done cycles %0d and %0d", lo, first, second);
      repeat (3) @(negedge clock);
      check("b2b_idle", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
